// File: rtl/mbadd_pkg.sv
// Shared definitions for the sequential multibyte adder.
//   state_e        : FSM state encoding (IDLE, RUN, DONE)
//   BYTE_W         : width of one operand byte
//   NBYTES_DEFAULT : default operand width in bytes
package mbadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned NBYTES_DEFAULT = 4;

endpackage

// File: rtl/adder8b.sv
// 8-bit ripple-carry adder, purely combinational.
// Ports:
//   a_i, b_i : 8-bit addends
//   cin_i    : carry into bit 0
//   sum_o    : 8-bit sum
//   cout_o   : carry out of bit 7
module adder8b (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    logic [8:0] carry;

    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < 8; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[8];
    end

endmodule

// File: rtl/multibyte_adder_seq.sv
// Sequential multibyte adder: adds two NBYTES-byte operands one byte per cycle
// through a single adder8b, with valid/ready handshakes on both sides.
// Optional feature: define MBADD_OVERFLOW_EN to add the registered signed
// overflow output out_ovf.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   in_a, in_b, in_cin  : operands and carry into the least significant byte
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   out_sum, out_cout   : A+B+cin and carry out of the most significant byte
//   out_ovf             : signed overflow (MBADD_OVERFLOW_EN only)
module multibyte_adder_seq
    import mbadd_pkg::*;
#(
    parameter int unsigned NBYTES = NBYTES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                     out_cout
`ifdef MBADD_OVERFLOW_EN
    ,
    output logic                     out_ovf
`endif
);

    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e                         state_q;
    logic [IDX_W-1:0]               idx_q;
    logic                           carry_q;
    logic [NBYTES-1:0][BYTE_W-1:0]  a_q;
    logic [NBYTES-1:0][BYTE_W-1:0]  b_q;
    logic [NBYTES-1:0][BYTE_W-1:0]  sum_q;
    logic                           cout_q;

    logic [BYTE_W-1:0]              a_byte;
    logic [BYTE_W-1:0]              b_byte;
    logic [BYTE_W-1:0]              byte_sum;
    logic                           byte_cout;

    assign a_byte = a_q[idx_q];
    assign b_byte = b_q[idx_q];

    adder8b u_adder (
        .a_i    (a_byte),
        .b_i    (b_byte),
        .cin_i  (carry_q),
        .sum_o  (byte_sum),
        .cout_o (byte_cout)
    );

`ifdef MBADD_OVERFLOW_EN
    logic ovf_q;
    logic msb_cin;

    // Carry into bit 7 of the top byte, recovered from its sum bit.
    assign msb_cin = a_byte[BYTE_W-1] ^ b_byte[BYTE_W-1] ^ byte_sum[BYTE_W-1];
    assign out_ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef MBADD_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= byte_sum;
                    carry_q      <= byte_cout;
                    idx_q        <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= byte_cout;
`ifdef MBADD_OVERFLOW_EN
                        ovf_q   <= msb_cin ^ byte_cout;
`endif
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_multibyte_adder_seq.sv
// Self-checking bench for multibyte_adder_seq (NBYTES = 4). Directed cases
// plus randomized operands, checked against an arithmetic reference model.
module tb_multibyte_adder_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
`ifdef MBADD_OVERFLOW_EN
    logic          out_ovf;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multibyte_adder_seq #(
        .NBYTES (NB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef MBADD_OVERFLOW_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision sum; bit W is the carry out.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    endfunction

    // Reference: signed result out of the W-bit two's-complement range.
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin);
        longint sa;
        longint sb;
        longint ss;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ss = sa + sb + longint'(cin);
        return (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    endfunction

    task automatic check_outputs(input string tag, input logic [W:0] exp,
                                 input logic exp_ovf);
        check({tag, ":sum"}, out_sum, exp[W-1:0]);
        check({tag, ":cout"}, out_cout, exp[W]);
`ifdef MBADD_OVERFLOW_EN
        check({tag, ":ovf"}, out_ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("unexpected x in overflow model");
`endif
    endtask

    // One full transaction. junk: keep in_valid high with changing operands
    // while busy. hold: cycles out_ready stays low in DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int hold, input bit junk, input string tag);
        logic [W:0] exp;
        logic       exp_ovf;
        int         cyc;
        exp     = ref_add(a, b, cin);
        exp_ovf = ref_ovf(a, b, cin);
        check({tag, ":ready_idle"}, in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (!junk) in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            check({tag, ":ready_busy"}, in_ready, 0);
            if (junk) begin
                in_a   = $urandom;
                in_b   = $urandom;
                in_cin = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ":latency"}, 64'(cyc), 64'(NB));
        check_outputs(tag, exp, exp_ovf);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ":valid_hold"}, out_valid, 1);
            check({tag, ":sum_hold"}, out_sum, exp[W-1:0]);
            check({tag, ":ready_done"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ":ready_after"}, in_ready, 1);
        check({tag, ":valid_after"}, out_valid, 0);
        check_outputs({tag, ":after"}, exp, exp_ovf);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst:in_ready", in_ready, 1);
        check("rst:out_valid", out_valid, 0);
        check_outputs("rst", '0, 1'b0);

        // First accept on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, "wrap");
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 0, 1'b0, "cin1");
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 10, 1'b0, "stall10");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, "ovf_pos");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0, "ovf_neg");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, "all_ones");
        run_op(32'hCAFE_0001, 32'h0000_00FF, 1'b0, 1, 1'b1, "junk");

        // Abort during byte 2 of RUN.
        in_a     = 32'hA5A5_A5A5;
        in_b     = 32'h5A5A_5A5A;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort:out_valid", out_valid, 0);
        check("abort:in_ready", in_ready, 1);
        check_outputs("abort", '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < NB + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort:no_result", 64'(seen), 0);
        check("abort:sum_zero", out_sum, 0);
        run_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 0, 1'b0, "post_abort");

        for (int i = 0; i < 40; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multibyte_adder_seq.md
MULTIBYTE_ADDER_SEQ -- requirements
Module: multibyte_adder_seq

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving operand width in bytes; legal range 1..16.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 Port in_valid, input, 1 bit: operands present.
REQ-005 Port in_ready, output, 1 bit: block can accept operands.
REQ-006 Port in_a, input, 8*NBYTES bits: operand A.
REQ-007 Port in_b, input, 8*NBYTES bits: operand B.
REQ-008 Port in_cin, input, 1 bit: carry into the least significant byte.
REQ-009 Port out_valid, output, 1 bit: result present.
REQ-010 Port out_ready, input, 1 bit: consumer takes the result.
REQ-011 Port out_sum, output, 8*NBYTES bits: A+B+cin modulo 2^(8*NBYTES).
REQ-012 Port out_cout, output, 1 bit: carry out of the most significant byte.
REQ-013 Port out_ovf, output, 1 bit: two's-complement signed overflow; present only per REQ-030.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 in IDLE and 0 in RUN and DONE, decoded from state only.
REQ-016 In IDLE with in_valid=1, the rising edge SHALL register in_a, in_b and in_cin, clear the byte index to 0, and enter RUN.
REQ-017 In RUN, each cycle SHALL add byte[idx] of A and B with the carry register through one 8-bit ripple adder, store the sum byte at out_sum[idx], update the carry register, and increment idx.
REQ-018 The carry register SHALL be loaded from in_cin on accept, and the byte-0 addition SHALL use that value.
REQ-019 After processing byte NBYTES-1, the block SHALL register out_cout and enter DONE; out_valid SHALL rise exactly NBYTES cycles after the accepting edge.
REQ-020 In DONE, out_valid SHALL be 1, and out_sum, out_cout and out_ovf SHALL stay stable until out_ready=1.
REQ-021 In DONE with out_ready=1, the edge SHALL return the FSM to IDLE; at most one new accept SHALL occur per result, so throughput is one result per NBYTES+2 cycles at best.
REQ-022 in_valid asserted in RUN or DONE SHALL be ignored, with no effect on operands or state.
REQ-023 Result outputs SHALL hold their last values after the output handshake; out_valid is the sole qualifier.
REQ-024 With NBYTES=1, RUN SHALL last exactly one cycle.

Reset
REQ-025 While rst_n=0, the state SHALL be IDLE and idx, the carry register, the operand registers, out_sum, out_cout and out_ovf SHALL be 0.
REQ-026 While rst_n=0, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation without producing a result.
REQ-028 The first accept after rst_n deasserts SHALL be possible on the first rising edge at which rst_n=1.

Configuration
REQ-029 Macro MBADD_OVERFLOW_EN SHALL control the signed-overflow feature.
REQ-030 With MBADD_OVERFLOW_EN defined, port out_ovf SHALL exist and SHALL be registered with out_cout as (carry into MSB) XOR (carry out of MSB).
REQ-031 Without MBADD_OVERFLOW_EN, port out_ovf and its logic SHALL be absent, with all other behaviour unchanged.

Structure
REQ-032 Shared package mbadd_pkg SHALL hold the state enum (IDLE, RUN, DONE), the BYTE_W=8 constant and the NBYTES_DEFAULT=4 constant.
REQ-033 The per-cycle byte addition SHALL be a single instance of the team's existing adder8b sub-module; no other arithmetic SHALL be used for the sum.
REQ-034 The idx width SHALL be $clog2(NBYTES), minimum 1.

Verification
REQ-035 A=0xFFFFFFFF, B=0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1, out_valid 4 cycles after accept.
REQ-036 A=0x12345678, B=0x11111111, cin=1 -> out_sum=0x2345678A, out_cout=0; in_ready=0 from accept until the result handshake.
REQ-037 out_ready held 0 for 10 cycles in DONE -> out_valid stays 1 and out_sum stays constant; handshake then gives in_ready=1 on the next cycle.
REQ-038 With MBADD_OVERFLOW_EN: A=0x7FFFFFFF, B=0x00000001 -> out_ovf=1, out_cout=0; A=0xFFFFFFFF, B=0x00000001 -> out_ovf=0, out_cout=1.
REQ-039 rst_n pulsed low during RUN byte 2 -> out_valid never rises, all outputs 0, and the next accept completes correctly.
REQ-040 New in_valid driven with different operands during RUN -> ignored; the result matches the first accepted operands.
